reg_file_param: RTL and testbench
=================================

# reg_file_param

Parametrised RISC-V integer register file, successor to the fixed 32×64 read-only register file driven by the instruction decoder. It decodes rs1, rs2 and rd directly from a 32-bit instruction, provides two read ports and one synchronous write port, and hardwires x0 to zero. It adds optional write-to-read bypass, an optional one-cycle registered read stage, and per-register "written since reset" tracking. It sits between instruction fetch/decode and the ALU in the single-cycle and pipelined datapaths.

## Interface
- WIDTH, 64, data width of each register (32 or 64)
- DEPTH, 32, number of registers; power of two, 2..32; address width AW = log2(DEPTH)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns old value
- READ_REG, 0, 0 = combinational read; 1 = read data registered (1-cycle latency)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- instruction  input  32  rs1 = [19:15], rs2 = [24:20], rd = [11:7]; low AW bits used
- RegWrite  input  1  write enable for rd
- WriteData  input  WIDTH  data written to rd
- ReadData1  output  WIDTH  value of rs1
- ReadData2  output  WIDTH  value of rs2
- Valid1  output  1  rs1 written since reset, or rs1 = 0
- Valid2  output  1  rs2 written since reset, or rs2 = 0

## Operation
- Storage: DEPTH × WIDTH array plus DEPTH-bit written mask.
- Reset (reset = 1 at a rising edge): all registers cleared to 0; mask cleared; the READ_REG output registers cleared to 0, and their valid registers cleared to 1. reset overrides RegWrite in the same cycle.
- Write: at a rising edge with RegWrite = 1, rd ≠ 0 and reset = 0:
  - reg[rd] ← WriteData;
  - mask[rd] ← 1.
- Writes to rd = 0 are discarded. The mask bit for x0 stays 0.
- Read value, before the optional output register:
  - If addr = 0: 0.
  - Else if BYPASS = 1, RegWrite = 1 and addr = rd: WriteData.
  - Else: reg[addr].
- Read valid: 1 if addr = 0; 1 if the same bypass condition applies; otherwise mask[addr].
- READ_REG = 0: ReadData/Valid are combinational from the current instruction and array.
- READ_REG = 1: ReadData/Valid are the read value/valid captured at the rising edge, so they reflect the instruction of the previous cycle. With BYPASS = 1 the captured value includes that edge's write.
- Address bits above AW are ignored. Indices alias modulo DEPTH; e.g. DEPTH = 16 with rs1 = 17 reads x1.

## Timing
- Write latency: one edge. reg[rd] is updated at the rising edge where RegWrite is sampled high.
- Read latency, READ_REG = 0: zero cycles, combinational.
  - BYPASS = 0: a register written at edge N shows its new value after edge N.
  - BYPASS = 1: the new value is visible in the same cycle as the write, before edge N.
- Read latency, READ_REG = 1: one cycle from instruction to output.
- Outputs immediately after reset:
  - ReadData1/2 = 0;
  - Valid1/2 = 1 only for x0 addresses, or with READ_REG = 1 (registered valids cleared to 1); otherwise 0.
- Reset mid-write: the write is lost and the register reads 0 afterwards.
- Simultaneous events:
  - rs1 = rs2 = rd with a write gives both ports the same value.
  - RegWrite with rd = 0 has no effect on state or outputs.

## Test plan
- Reset, then instruction 0x01EF8000 (rs1 = 31, rs2 = 30) -> ReadData1 = ReadData2 = 0, Valid1 = Valid2 = 0.
- Write x31 = 0xDEADBEEF_00000001 (rd = 31, RegWrite = 1), next cycle read rs1 = 31 -> ReadData1 = 0xDEADBEEF_00000001, Valid1 = 1. Repeat with x30 -> ReadData2 = written value.
- Write x0 = 0xFFFF_FFFF_FFFF_FFFF, then read rs1 = 0 -> ReadData1 = 0, Valid1 = 1.
- BYPASS = 1, same cycle RegWrite = 1, rd = rs1 = 15, WriteData = 0x1234 -> ReadData1 = 0x1234 before the edge. Repeat with BYPASS = 0 -> old value (0) before the edge, 0x1234 after.
- READ_REG = 1: change rs2 from 14 (holding 0xAA) to 28 (holding 0x55) -> ReadData2 stays 0xAA for one cycle, then 0x55.
- Assert reset during RegWrite to x14 with x14 previously 0x77 -> x14 reads 0 after reset, Valid for x14 = 0. Also DEPTH = 16, WIDTH = 32: write rd = 1, read rs1 = 17 -> returns the x1 value.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised RISC-V integer register file: two read ports, one write port,
// x0 hardwired to zero, optional write bypass, optional registered read.
module reg_file_param #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             RegWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic             Valid1,
    output logic             Valid2
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW-1:0] addr_t;

    addr_t rs1;
    addr_t rs2;
    addr_t rd;

    // Upper index bits are dropped so indices alias modulo DEPTH.
    assign rs1 = instruction[15 +: AW];
    assign rs2 = instruction[20 +: AW];
    assign rd  = instruction[7 +: AW];

    logic unused_instr;
    assign unused_instr = ^instruction;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] mask_q;
    logic             wr_en;
    logic             byp_en;

    assign wr_en  = RegWrite && (rd != '0);
    assign byp_en = (BYPASS != 0) && wr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            mask_q <= '0;
        end else if (wr_en) begin
            regs_q[rd] <= WriteData;
            mask_q[rd] <= 1'b1;
        end
    end

    function automatic logic [WIDTH:0] read_port(
        input addr_t            a,
        input addr_t            w,
        input logic             byp,
        input logic [WIDTH-1:0] wd,
        input logic [WIDTH-1:0] q,
        input logic             m
    );
        logic [WIDTH:0] r;
        r = {m, q};
        if (a == '0) begin
            r = {1'b1, {WIDTH{1'b0}}};
        end else if (byp && (a == w)) begin
            r = {1'b1, wd};
        end
        return r;
    endfunction

    logic [WIDTH-1:0] rdata1_d;
    logic [WIDTH-1:0] rdata2_d;
    logic             valid1_d;
    logic             valid2_d;

    always_comb begin
        {valid1_d, rdata1_d} = read_port(rs1, rd, byp_en, WriteData,
                                         regs_q[rs1], mask_q[rs1]);
        {valid2_d, rdata2_d} = read_port(rs2, rd, byp_en, WriteData,
                                         regs_q[rs2], mask_q[rs2]);
    end

    if (READ_REG != 0) begin : g_rd_reg
        logic [WIDTH-1:0] rdata1_q;
        logic [WIDTH-1:0] rdata2_q;
        logic             valid1_q;
        logic             valid2_q;

        // Valids reset high so the pipeline stage reads as "known zero".
        always_ff @(posedge clk) begin
            if (reset) begin
                rdata1_q <= '0;
                rdata2_q <= '0;
                valid1_q <= 1'b1;
                valid2_q <= 1'b1;
            end else begin
                rdata1_q <= rdata1_d;
                rdata2_q <= rdata2_d;
                valid1_q <= valid1_d;
                valid2_q <= valid2_d;
            end
        end

        assign ReadData1 = rdata1_q;
        assign ReadData2 = rdata2_q;
        assign Valid1    = valid1_q;
        assign Valid2    = valid2_q;
    end else begin : g_rd_comb
        assign ReadData1 = rdata1_d;
        assign ReadData2 = rdata2_d;
        assign Valid1    = valid1_d;
        assign Valid2    = valid2_d;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: four parameter variants share stimulus,
// expectations are queued at drive time and drained at the falling edge.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        RegWrite;
    logic [63:0] WriteData;

    always #5 clk = ~clk;

    logic [63:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2;
    logic [31:0] d_rd1, d_rd2;
    logic        a_v1, a_v2, b_v1, b_v2, c_v1, c_v2, d_v1, d_v2;

    reg_file_param u_a (
        .clk(clk), .reset(reset), .instruction(instruction),
        .RegWrite(RegWrite), .WriteData(WriteData),
        .ReadData1(a_rd1), .ReadData2(a_rd2),
        .Valid1(a_v1), .Valid2(a_v2)
    );

    reg_file_param #(.BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .instruction(instruction),
        .RegWrite(RegWrite), .WriteData(WriteData),
        .ReadData1(b_rd1), .ReadData2(b_rd2),
        .Valid1(b_v1), .Valid2(b_v2)
    );

    reg_file_param #(.READ_REG(1)) u_c (
        .clk(clk), .reset(reset), .instruction(instruction),
        .RegWrite(RegWrite), .WriteData(WriteData),
        .ReadData1(c_rd1), .ReadData2(c_rd2),
        .Valid1(c_v1), .Valid2(c_v2)
    );

    reg_file_param #(.WIDTH(32), .DEPTH(16)) u_d (
        .clk(clk), .reset(reset), .instruction(instruction),
        .RegWrite(RegWrite), .WriteData(WriteData[31:0]),
        .ReadData1(d_rd1), .ReadData2(d_rd2),
        .Valid1(d_v1), .Valid2(d_v2)
    );

    localparam int A = 0, B = 4, C = 8, D = 12;
    localparam int RD1 = 0, RD2 = 1, V1 = 2, V2 = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    function automatic logic [63:0] obs(int sel);
        case (sel)
            A + RD1: return a_rd1;
            A + RD2: return a_rd2;
            A + V1:  return {63'b0, a_v1};
            A + V2:  return {63'b0, a_v2};
            B + RD1: return b_rd1;
            B + RD2: return b_rd2;
            B + V1:  return {63'b0, b_v1};
            B + V2:  return {63'b0, b_v2};
            C + RD1: return c_rd1;
            C + RD2: return c_rd2;
            C + V1:  return {63'b0, c_v1};
            C + V2:  return {63'b0, c_v2};
            D + RD1: return {32'b0, d_rd1};
            D + RD2: return {32'b0, d_rd2};
            D + V1:  return {63'b0, d_v1};
            D + V2:  return {63'b0, d_v2};
            default: return 'x;
        endcase
    endfunction

    function automatic logic [31:0] mk(int s1, int s2, int d);
        return {7'b0, 5'(s2), 5'(s1), 3'b0, 5'(d), 7'h33};
    endfunction

    task automatic drive(input logic r, input logic [31:0] ins,
                         input logic we, input logic [63:0] wd);
        @(posedge clk);
        #1;
        reset       = r;
        instruction = ins;
        RegWrite    = we;
        WriteData   = wd;
    endtask

    task automatic want(input string tag, input int sel,
                        input logic [63:0] v);
        sb_q.push_back('{tag, sel, v});
    endtask

    task automatic check();
        sb_t         it;
        logic [63:0] o;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            o  = obs(it.sel);
            n_cmp++;
            assert (o === it.exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h",
                       it.tag, o, it.exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        instruction = '0;
        RegWrite    = 1'b0;
        WriteData   = '0;
        repeat (2) @(posedge clk);

        drive(0, 32'h01EF8000, 0, 0);
        want("rst_a_rd1", A + RD1, 0);
        want("rst_a_rd2", A + RD2, 0);
        want("rst_a_v1", A + V1, 0);
        want("rst_a_v2", A + V2, 0);
        want("rst_c_rd1", C + RD1, 0);
        want("rst_c_v1", C + V1, 1);
        want("rst_c_v2", C + V2, 1);
        want("rst_d_v1", D + V1, 0);
        check();

        drive(0, mk(0, 0, 31), 1, 64'hDEADBEEF_00000001);
        drive(0, mk(31, 30, 0), 0, 0);
        want("x31_a_rd1", A + RD1, 64'hDEADBEEF_00000001);
        want("x31_a_v1", A + V1, 1);
        want("x31_a_v2", A + V2, 0);
        want("x31_b_rd1", B + RD1, 64'hDEADBEEF_00000001);
        want("alias_d_rd1", D + RD1, 64'h1);
        want("alias_d_v1", D + V1, 1);
        check();

        drive(0, mk(0, 0, 30), 1, 64'h01234567_89ABCDEF);
        drive(0, mk(31, 30, 0), 0, 0);
        want("x30_a_rd2", A + RD2, 64'h01234567_89ABCDEF);
        want("x30_a_v2", A + V2, 1);
        want("x30_d_rd2", D + RD2, 64'h89ABCDEF);
        check();

        drive(0, mk(0, 0, 0), 1, '1);
        want("x0wr_a_rd1", A + RD1, 0);
        want("x0wr_a_v1", A + V1, 1);
        want("x0wr_b_rd1", B + RD1, 0);
        check();
        drive(0, mk(0, 0, 0), 0, 0);
        want("x0rd_a_rd1", A + RD1, 0);
        want("x0rd_a_v1", A + V1, 1);
        check();

        drive(0, mk(15, 15, 15), 1, 64'h1234);
        want("byp_a_rd1", A + RD1, 64'h1234);
        want("byp_a_rd2", A + RD2, 64'h1234);
        want("byp_a_v1", A + V1, 1);
        want("nobyp_b_rd1", B + RD1, 0);
        want("nobyp_b_v1", B + V1, 0);
        want("byp_d_rd1", D + RD1, 64'h1234);
        check();
        drive(0, mk(15, 15, 0), 0, 0);
        want("post_b_rd1", B + RD1, 64'h1234);
        want("post_b_rd2", B + RD2, 64'h1234);
        want("post_b_v1", B + V1, 1);
        check();

        drive(0, mk(0, 0, 14), 1, 64'hAA);
        drive(0, mk(0, 0, 28), 1, 64'h55);
        drive(0, mk(0, 14, 0), 0, 0);
        want("rr0_c_rd2", C + RD2, 0);
        check();
        drive(0, mk(0, 28, 0), 0, 0);
        want("rr1_c_rd2", C + RD2, 64'hAA);
        want("rr1_c_v2", C + V2, 1);
        want("rr1_a_rd2", A + RD2, 64'h55);
        check();
        drive(0, mk(0, 28, 0), 0, 0);
        want("rr2_c_rd2", C + RD2, 64'h55);
        check();

        drive(0, mk(20, 0, 20), 1, 64'h99);
        drive(0, mk(0, 0, 0), 0, 0);
        want("rrbyp_c_rd1", C + RD1, 64'h99);
        want("rrbyp_c_v1", C + V1, 1);
        check();

        drive(0, mk(0, 0, 14), 1, 64'h77);
        drive(1, mk(0, 0, 14), 1, 64'h88);
        drive(0, mk(14, 0, 0), 0, 0);
        want("rstwr_a_rd1", A + RD1, 0);
        want("rstwr_a_v1", A + V1, 0);
        want("rstwr_a_v2", A + V2, 1);
        want("rstwr_b_rd1", B + RD1, 0);
        want("rstwr_c_rd1", C + RD1, 0);
        want("rstwr_c_v1", C + V1, 1);
        check();
        drive(0, mk(14, 0, 0), 0, 0);
        want("rstwr2_c_rd1", C + RD1, 0);
        want("rstwr2_c_v1", C + V1, 0);
        check();

        drive(0, mk(0, 0, 1), 1, 64'hCAFEF00D_12345678);
        drive(0, mk(17, 0, 0), 0, 0);
        want("d16_d_rd1", D + RD1, 64'h12345678);
        want("d16_d_v1", D + V1, 1);
        want("d16_a_rd1", A + RD1, 0);
        want("d16_a_v1", A + V1, 0);
        check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
